// File: rtl/time_set_controller.sv
// Time-entry controller: debounced mode/inc buttons drive an hours->minutes->seconds edit and a BCD load strobe.
// Latency: 2 sync + DEBOUNCE_CYCLES to the debounced level, +1 cycle to the event; outputs update on the consuming edge.
// Backpressure: none; the counter must accept load whenever it pulses. Optional auto-repeat: TIME_SET_AUTOREPEAT_EN.
module time_set_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_CYCLES    = 12_500_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hr_tens,
   input  logic [3:0] cur_hr_ones,
   input  logic [3:0] cur_min_tens,
   input  logic [3:0] cur_min_ones,
   input  logic [3:0] cur_sec_tens,
   input  logic [3:0] cur_sec_ones,
   output logic [3:0] set_hr_tens,
   output logic [3:0] set_hr_ones,
   output logic [3:0] set_min_tens,
   output logic [3:0] set_min_ones,
   output logic [3:0] set_sec_tens,
   output logic [3:0] set_sec_ones,
   output logic       set_active,
   output logic       load,
   output logic [1:0] field_sel,
   output logic       blink
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

   // State encoding doubles as the field_sel code.
   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10,
      SET_SEC = 2'b11
   } state_e;

   // Bit 0 = mode button, bit 1 = increment button.
   logic [1:0]         sync1_q, sync2_q, deb_q, deb_prev_q;
   logic [1:0][DW-1:0] db_cnt_q;
   logic               mode_evt, inc_press, inc_evt, in_set;

   state_e             state_q, state_d;
   logic [2:0][7:0]    val_q, val_d;      // [0]=hours [1]=minutes [2]=seconds, each {tens,ones}
   logic               load_q, load_d;
   logic               blink_q, blink_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;

   // Increment a BCD pair, wrapping at 23 for hours and at 59 otherwise.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic is_hr);
      logic [3:0] t, o;
      t = v[7:4];
      o = v[3:0];
      if (is_hr && t == 4'd2 && o == 4'd3) return 8'h00;
      if (o == 4'd9) begin
         if (!is_hr && t == 4'd5) return 8'h00;
         return {t + 4'd1, 4'd0};
      end
      return {t, o + 4'd1};
   endfunction

   // Out-of-range or non-BCD snapshots enter the edit as 00.
   function automatic logic [7:0] sanitize(input logic [3:0] t, input logic [3:0] o, input logic is_hr);
      logic ok;
      ok = (t <= 4'd9) && (o <= 4'd9);
      if (is_hr) ok = ok && ((t < 4'd2) || (t == 4'd2 && o <= 4'd3));
      else       ok = ok && (t <= 4'd5);
      return ok ? {t, o} : 8'h00;
   endfunction

   // Synchronize both buttons and accept a level only after it has been stable long enough.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         db_cnt_q   <= '0;
      end else begin
         sync1_q    <= {btn_inc, btn_mode};
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
               if (db_cnt_q[i] == DB_LAST) begin
                  deb_q[i]    <= sync2_q[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign mode_evt  = deb_q[0] & ~deb_prev_q[0];
   assign inc_press = deb_q[1] & ~deb_prev_q[1];
   assign in_set    = (state_q != RUN);

`ifdef TIME_SET_AUTOREPEAT_EN
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt_q;
   logic          rep_phase_q;   // 0 = waiting out the initial hold, 1 = repeating
   logic          rep_fire;

   assign rep_fire = in_set && deb_q[1] &&
                     (rep_phase_q ? (rep_cnt_q == REP_LAST) : (rep_cnt_q == HOLD_LAST));
   assign inc_evt  = inc_press | rep_fire;

   // Time a held increment button; release, a mode event or leaving edit restarts the hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else if (!in_set || !deb_q[1] || mode_evt) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b1;
      end else begin
         rep_cnt_q   <= rep_cnt_q + 1'b1;
      end
   end
`else
   assign inc_evt = inc_press;
`endif

   // Edit-state, digit, load and blink registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         val_q   <= '0;
         load_q  <= 1'b0;
         blink_q <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         load_q  <= load_d;
         blink_q <= blink_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Next state: mode walks the fields (and wins over inc), inc steps the selected field, blink free-runs otherwise.
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      load_d  = 1'b0;
      blink_d = blink_q;
      bcnt_d  = bcnt_q;
      if (state_q == RUN) begin
         blink_d = 1'b0;
         bcnt_d  = '0;
         if (mode_evt) begin
            state_d  = SET_HR;
            val_d[0] = sanitize(cur_hr_tens,  cur_hr_ones,  1'b1);
            val_d[1] = sanitize(cur_min_tens, cur_min_ones, 1'b0);
            val_d[2] = sanitize(cur_sec_tens, cur_sec_ones, 1'b0);
            blink_d  = 1'b1;
         end
      end else if (mode_evt) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
         case (state_q)
            SET_HR:  state_d = SET_MIN;
            SET_MIN: state_d = SET_SEC;
            default: begin
               state_d = RUN;
               load_d  = 1'b1;
               blink_d = 1'b0;
            end
         endcase
      end else if (inc_evt) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
         case (state_q)
            SET_HR:  val_d[0] = bcd_inc(val_q[0], 1'b1);
            SET_MIN: val_d[1] = bcd_inc(val_q[1], 1'b0);
            default: val_d[2] = bcd_inc(val_q[2], 1'b0);
         endcase
      end else if (bcnt_q == BL_LAST) begin
         blink_d = ~blink_q;
         bcnt_d  = '0;
      end else begin
         bcnt_d  = bcnt_q + 1'b1;
      end
   end

   assign set_hr_tens  = val_q[0][7:4];
   assign set_hr_ones  = val_q[0][3:0];
   assign set_min_tens = val_q[1][7:4];
   assign set_min_ones = val_q[1][3:0];
   assign set_sec_tens = val_q[2][7:4];
   assign set_sec_ones = val_q[2][3:0];
   assign set_active   = in_set;
   assign field_sel    = state_q;
   assign load         = load_q;
   assign blink        = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus randomized edit sessions against an integer time model.
// Latency: each button press is held 8 cycles and released 8 cycles, well past the debounce window.
// Backpressure: none; load pulses are captured by a monitor on every cycle.
module tb_time_set_controller;

   localparam int DEB = 4;
   localparam int BLK = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0;
   logic [3:0] cur_hr_tens = '0, cur_hr_ones = '0, cur_min_tens = '0;
   logic [3:0] cur_min_ones = '0, cur_sec_tens = '0, cur_sec_ones = '0;
   logic [3:0] set_hr_tens, set_hr_ones, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones;
   logic       set_active, load, blink;
   logic [1:0] field_sel;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integer hours/minutes/seconds and field index.
   int m_state = 0;
   int m_h = 0, m_m = 0, m_s = 0;
   int m_loads = 0;

   // Monitor captures.
   int load_cnt = 0;
   int load_sa = 0, load_fs = 0, load_val = 0;
   int run_len = 0, last_run = 0;
   bit measuring = 1'b0;
   logic [1:0] prev_fs = 2'b00;

   time_set_controller #(
      .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
   ) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hr_tens(cur_hr_tens), .cur_hr_ones(cur_hr_ones),
      .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
      .cur_sec_tens(cur_sec_tens), .cur_sec_ones(cur_sec_ones),
      .set_hr_tens(set_hr_tens), .set_hr_ones(set_hr_ones),
      .set_min_tens(set_min_tens), .set_min_ones(set_min_ones),
      .set_sec_tens(set_sec_tens), .set_sec_ones(set_sec_ones),
      .set_active(set_active), .load(load), .field_sel(field_sel), .blink(blink)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Packed-digit view of a 0..99 value, as the DUT presents it.
   function automatic int bcd(input int v);
      return ((v / 10) << 4) | (v % 10);
   endfunction

   function automatic int all_digits();
      return {8'h0, set_hr_tens, set_hr_ones, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones};
   endfunction

   // Observe load pulses and the length of the first blink-high run after each field change.
   always @(negedge clk) begin
      if (reset && load) begin
         load_cnt++;
         load_sa  = int'(set_active);
         load_fs  = int'(field_sel);
         load_val = all_digits();
      end
      if (field_sel != prev_fs) begin
         run_len   = blink ? 1 : 0;
         measuring = 1'b1;
      end else if (measuring) begin
         if (blink) run_len++;
         else begin
            last_run  = run_len;
            measuring = 1'b0;
         end
      end
      prev_fs = field_sel;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cur(input int ht, input int ho, input int mt, input int mo, input int st, input int so);
      cur_hr_tens  = 4'(ht); cur_hr_ones  = 4'(ho);
      cur_min_tens = 4'(mt); cur_min_ones = 4'(mo);
      cur_sec_tens = 4'(st); cur_sec_ones = 4'(so);
   endtask

   function automatic int field_val(input int t, input int o, input int lim);
      int v;
      v = t * 10 + o;
      if (t > 9 || o > 9 || v > lim) v = 0;
      return v;
   endfunction

   task automatic model_mode();
      if (m_state == 0) begin
         m_h = field_val(int'(cur_hr_tens),  int'(cur_hr_ones),  23);
         m_m = field_val(int'(cur_min_tens), int'(cur_min_ones), 59);
         m_s = field_val(int'(cur_sec_tens), int'(cur_sec_ones), 59);
         m_state = 1;
      end else if (m_state == 3) begin
         m_state = 0;
         m_loads++;
      end else begin
         m_state++;
      end
   endtask

   task automatic model_inc();
      case (m_state)
         1: m_h = (m_h + 1) % 24;
         2: m_m = (m_m + 1) % 60;
         3: m_s = (m_s + 1) % 60;
         default: ;
      endcase
   endtask

   // One clean press of the chosen buttons; mode takes precedence in the model as well.
   task automatic press(input bit do_mode, input bit do_inc);
      @(negedge clk);
      btn_mode = do_mode;
      btn_inc  = do_inc;
      cyc(2 * DEB);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(2 * DEB);
      if (do_mode) model_mode();
      else if (do_inc) model_inc();
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".hr"},  {set_hr_tens,  set_hr_ones},  bcd(m_h));
      check_eq({tag, ".min"}, {set_min_tens, set_min_ones}, bcd(m_m));
      check_eq({tag, ".sec"}, {set_sec_tens, set_sec_ones}, bcd(m_s));
      check_eq({tag, ".field_sel"}, int'(field_sel), m_state);
      check_eq({tag, ".set_active"}, int'(set_active), (m_state != 0) ? 1 : 0);
      if (m_state == 0) check_eq({tag, ".blink_run"}, int'(blink), 0);
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, ".digits"}, all_digits(), 0);
      check_eq({tag, ".set_active"}, int'(set_active), 0);
      check_eq({tag, ".load"}, int'(load), 0);
      check_eq({tag, ".field_sel"}, int'(field_sel), 0);
      check_eq({tag, ".blink"}, int'(blink), 0);
   endtask

   initial begin
      int lc, n_inc, op;

      // Reset state.
      cyc(3);
      check_idle_zero("reset");
      reset = 1'b1;
      cyc(3);

      // Bounce rejection: 20 cycles of 2-cycle toggling, then a clean 10-cycle press.
      set_cur(0, 9, 4, 5, 1, 7);
      for (int i = 0; i < 10; i++) begin
         btn_mode = ~btn_mode;
         cyc(2);
      end
      check_eq("bounce.no_event", int'(field_sel), 0);
      btn_mode = 1'b1;
      cyc(10);
      btn_mode = 1'b0;
      cyc(10);
      model_mode();
      check_all("bounce");
      check_eq("bounce.blink_first_half", last_run, BLK);
      press(1, 0); press(1, 0); press(1, 0);
      check_eq("bounce.loads", load_cnt, m_loads);

      // Hour wrap 22 -> 23 -> 00.
      set_cur(2, 2, 5, 8, 3, 0);
      press(1, 0);
      press(0, 1);
      press(0, 1);
      check_all("hour_wrap");
      press(1, 0); press(1, 0); press(1, 0);

      // Full edit and load: 12:34:56 -> 12:37:57.
      set_cur(1, 2, 3, 4, 5, 6);
      press(1, 0);
      press(1, 0);
      press(0, 1); press(0, 1); press(0, 1);
      press(1, 0);
      press(0, 1);
      lc = load_cnt;
      press(1, 0);
      check_eq("load.pulses", load_cnt - lc, 1);
      check_eq("load.set_active_low", load_sa, 0);
      check_eq("load.field_sel", load_fs, 0);
      check_eq("load.value", load_val, 'h123757);
      set_cur(0, 1, 0, 2, 0, 3);
      cyc(6);
      check_all("load.hold");

      // Invalid snapshot, then a mode/inc collision.
      set_cur(2, 5, 6, 1, 0, 7);
      press(1, 0);
      check_all("invalid_snap");
      press(1, 1);
      check_all("collision");

      // Reset mid-edit in SET_MIN, asserted between clock edges.
      press(0, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_idle_zero("reset_mid");
      cyc(2);
      reset = 1'b1;
      m_state = 0; m_h = 0; m_m = 0; m_s = 0;
      lc = load_cnt;
      cyc(30);
      check_eq("reset_mid.no_load", load_cnt - lc, 0);
      check_all("reset_mid.after");

      // Randomized edit sessions with moving live time.
      m_loads = load_cnt;
      for (int it = 0; it < 6; it++) begin
         set_cur($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 7),
                 $urandom_range(0, 9), $urandom_range(0, 7), $urandom_range(0, 9));
         for (int k = 0; k < 12; k++) begin
            op = $urandom_range(0, 9);
            if (op < 2)      press(1, 0);
            else if (op < 9) press(0, 1);
            else             press(1, 1);
            check_all($sformatf("rand%0d_%0d", it, k));
            set_cur($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5),
                    $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
         end
         while (m_state != 0) press(1, 0);
         check_eq($sformatf("rand%0d.loads", it), load_cnt, m_loads);
      end

      // Long hold of inc in SET_SEC from 58.
      set_cur(0, 0, 0, 0, 5, 8);
      press(1, 0); press(1, 0); press(1, 0);
      @(negedge clk);
      btn_inc = 1'b1;
      cyc(52);
      btn_inc = 1'b0;
      cyc(12);
`ifdef TIME_SET_AUTOREPEAT_EN
      n_inc = 8;
`else
      n_inc = 1;
`endif
      for (int i = 0; i < n_inc; i++) model_inc();
      check_all("hold");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
